// File: rtl/fetch_prefetch_unit.sv
// IF-stage fetch engine: owns the fetch PC, issues one word request at a time
// to a request/grant instruction memory, buffers responses in a small FIFO and
// presents {instr, pc, pc+4} to the IF_ID register. Redirects flush the FIFO
// and drop any response still in flight for the old path.
module fetch_prefetch_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic          outstanding;
  logic          discard;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic        credit_ok;
  logic        issue;
  logic        resp_ok;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  // The in-flight request holds a FIFO slot so its response can never overflow.
  assign credit_ok       = (count + {{AW{1'b0}}, outstanding}) < DEPTH_C;
  assign imem_req_o      = rst_i & ~outstanding & credit_ok & ~redirect_i;
  assign imem_addr_o     = fetch_pc;
  assign issue           = imem_req_o & imem_gnt_i;
  assign resp_ok         = imem_rvalid_i & outstanding;
  assign push            = resp_ok & ~discard & ~redirect_i;
  assign pop             = instr_valid_o & ~stall_i & ~redirect_i;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

  // Fetch PC, outstanding-request tracking and wrong-path discard flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      pend_pc     <= 32'h0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (issue) begin
        outstanding <= 1'b1;
      end else if (resp_ok) begin
        outstanding <= 1'b0;
      end
      if (redirect_i) begin
        // A response arriving this very cycle is already being dropped.
        discard <= (outstanding & ~imem_rvalid_i) | issue;
      end else if (resp_ok) begin
        discard <= 1'b0;
      end
      if (redirect_i) begin
        fetch_pc <= redirect_target;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        pend_pc  <= fetch_pc;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata_i;
      fifo_pc[wr_ptr]    <= pend_pc;
    end
  end

  // Head presentation with idle values when the FIFO is empty.
  always_comb begin
    instr_valid_o = (count != '0);
    instr_o       = NOP_INSTR;
    pc_o          = 32'h0;
    pc_plus4_o    = 32'h0;
    if (instr_valid_o) begin
      instr_o    = fifo_instr[rd_ptr];
      pc_o       = fifo_pc[rd_ptr];
      pc_plus4_o = fifo_pc[rd_ptr] + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a variable-latency memory model
// drives the main instance, a second instance with a near-wrap RESET_PC uses
// a fixed one-cycle memory.
module tb_fetch_prefetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        gnt;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stray_rv;
  int          lat;

  logic        req, valid;
  logic [31:0] addr, instr, pc, pc4;
  logic        rvalid;
  logic [31:0] rdata;

  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;

  logic        req1, valid1, rv1;
  logic [31:0] addr1, instr1, pc1, pc41, a1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  fetch_prefetch_unit u0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
    .instr_valid_o(valid), .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc4)
  );

  fetch_prefetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_gnt_i(1'b1),
    .imem_rvalid_i(rv1), .imem_rdata_i(f(a1)),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .stall_i(1'b0),
    .instr_valid_o(valid1), .instr_o(instr1), .pc_o(pc1), .pc_plus4_o(pc41)
  );

  assign rvalid = stray_rv | (m_busy && m_cnt == 1);
  assign rdata  = stray_rv ? 32'hDEAD_BEEF : f(m_addr);

  // Main memory model: response lat cycles after the grant.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= 32'h0;
    end else if (req && gnt) begin
      m_busy <= 1'b1;
      m_cnt  <= lat;
      m_addr <= addr;
    end else if (m_busy) begin
      if (m_cnt == 1) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  // One-cycle memory for the wrap-around instance.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rv1 <= 1'b0;
      a1  <= 32'h0;
    end else begin
      rv1 <= req1;
      if (req1) a1 <= addr1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; gnt = 1'b1; lat = 1; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; stray_rv = 1'b0;
    #2;
    chk("rst_req",   req,   0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc",    pc,    0);
    chk("rst_pc4",   pc4,   0);

    // Stream with a 1-cycle memory.
    tick(); rst_i = 1'b1; #1;
    chk("c0_req",  req,  1);
    chk("c0_addr", addr, 32'h0);
    tick();
    chk("c1_req",   req,   0);
    chk("c1_valid", valid, 0);
    tick();
    chk("c2_valid", valid, 1);
    chk("c2_pc",    pc,    32'h0);
    chk("c2_pc4",   pc4,   32'h4);
    chk("c2_instr", instr, f(32'h0));
    chk("c2_addr",  addr,  32'h4);
    tick();
    chk("c3_valid", valid, 0);
    tick();
    chk("c4_pc", pc, 32'h4);

    // Stall until the FIFO fills.
    stall = 1'b1;
    repeat (20) tick();
    chk("full_valid", valid, 1);
    chk("full_pc",    pc,    32'h4);
    chk("full_instr", instr, f(32'h4));
    chk("full_req",   req,   0);
    chk("full_addr",  addr,  32'h14);
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_valid", valid, 1);
      chk("drain_pc",    pc,    32'h4 + 32'(4 * i));
    end

    // Redirect with a 5-cycle memory and a request in flight.
    lat = 5;
    tick();
    chk("c29_pc",   pc,   32'h18);
    chk("c29_addr", addr, 32'h1C);
    tick();
    chk("c30_valid", valid, 0);
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0102; #1;
    chk("rd1_req", req, 0);
    tick();
    redirect = 1'b0;
    chk("c33_addr",  addr,  32'h100);
    chk("c33_req",   req,   0);
    chk("c33_valid", valid, 0);
    tick();
    chk("c34_req", req, 0);
    tick();
    chk("c35_req",   req,   1);
    chk("c35_addr",  addr,  32'h100);
    chk("c35_valid", valid, 0);
    repeat (5) tick();
    chk("c40_valid", valid, 0);
    tick();
    chk("c41_valid", valid, 1);
    chk("c41_pc",    pc,    32'h100);
    chk("c41_pc4",   pc4,   32'h104);
    chk("c41_instr", instr, f(32'h100));

    // Redirect in the cycle that would have fetched 0x108.
    lat = 1;
    tick();
    chk("c42_req", req, 0);
    tick();
    chk("c43_pc",   pc,   32'h104);
    chk("c43_addr", addr, 32'h108);
    chk("c43_req",  req,  1);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
    chk("rd2_req", req, 0);
    tick();
    redirect = 1'b0; #1;
    chk("c44_valid", valid, 0);
    chk("c44_req",   req,   1);
    chk("c44_addr",  addr,  32'h200);
    tick();
    chk("c45_valid", valid, 0);
    tick();
    chk("c46_valid", valid, 1);
    chk("c46_pc",    pc,    32'h200);
    chk("c46_instr", instr, f(32'h200));

    // Async reset with two entries buffered and a request in flight.
    stall = 1'b1;
    tick();
    tick();
    chk("c48_addr", addr, 32'h208);
    lat = 3;
    tick();
    chk("c49_req",   req,   0);
    chk("c49_valid", valid, 1);
    chk("c49_pc",    pc,    32'h200);
    #2; rst_i = 1'b0; #1;
    chk("arst_valid", valid, 0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_pc",    pc,    0);
    chk("arst_pc4",   pc4,   0);
    chk("arst_req",   req,   0);
    stall = 1'b0; gnt = 1'b0;
    tick();
    rst_i = 1'b1; stray_rv = 1'b1; #1;
    chk("rel_req",  req,  1);
    chk("rel_addr", addr, 32'h0);
    tick();
    stray_rv = 1'b0; gnt = 1'b1; lat = 1; #1;
    chk("stray_valid", valid, 0);
    chk("stray_req",   req,   1);
    chk("stray_addr",  addr,  32'h0);
    tick();
    tick();
    chk("restart_valid", valid, 1);
    chk("restart_pc",    pc,    32'h0);
    chk("restart_instr", instr, f(32'h0));

    // Wrap-around instance.
    rst_i = 1'b0; #2;
    tick();
    rst_i = 1'b1; #1;
    chk("w0_req",  req1,  1);
    chk("w0_addr", addr1, 32'hFFFF_FFF8);
    tick();
    tick();
    chk("w2_valid", valid1, 1);
    chk("w2_pc",    pc1,    32'hFFFF_FFF8);
    chk("w2_pc4",   pc41,   32'hFFFF_FFFC);
    chk("w2_addr",  addr1,  32'hFFFF_FFFC);
    tick();
    tick();
    chk("w4_pc",    pc1,    32'hFFFF_FFFC);
    chk("w4_pc4",   pc41,   32'h0);
    chk("w4_instr", instr1, f(32'hFFFF_FFFC));
    chk("w4_addr",  addr1,  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
